// File: rtl/mini_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the mini ALU sequencer.
package mini_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_LCD_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_BRC  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_LCD  = 4'd4;
    localparam logic [3:0] OP_CALL = 4'd5;
    localparam logic [3:0] OP_RET  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

endpackage

// File: rtl/mini_seq_ret_stack.sv
// Return-address stack for CALL/RET; push and pop are ignored when full/empty.
module mini_seq_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] data
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_idx  = IDX_W'(count);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign data    = empty ? '0 : mem[top_idx];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge Clock) begin
        if (!Reset && push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/mini_alu_sequencer.sv
// Instruction sequencer: FETCH/EXEC over a 1-cycle-latency ROM, LCD handshake, HALT.
// Define MINI_SEQ_CALL_STACK_EN to add CALL/RET via a return-address stack.
//
// state       | meaning
// ST_FETCH    | IP presented to ROM, data arrives next cycle
// ST_EXEC     | decode opcode, update IP
// ST_LCD_WAIT | oLcdValid held until iLcdReady
// ST_HALT     | stopped, only Reset leaves
module mini_alu_sequencer
    import mini_seq_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oInstrAddr,
    input  logic [3:0]        iOpcode,
    input  logic [ADDR_W-1:0] iTarget,
    input  logic              iCond,
    output logic              oRegWrite,
    output logic              oLcdValid,
    input  logic              iLcdReady,
    output logic              oHalted,
    output logic              oFault
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ip, ip_nxt, ip_inc;
    logic              regwrite_nxt;

`ifdef MINI_SEQ_CALL_STACK_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_data;
    logic              fault_q, fault_set;

    mini_seq_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_ret_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (ip_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .data      (stk_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset)          fault_q <= 1'b0;
        else if (fault_set) fault_q <= 1'b1;
    end

    assign oFault = fault_q;
`else
    logic unused_stack_depth;
    assign unused_stack_depth = (STACK_DEPTH == 0);
    assign oFault             = 1'b0;
`endif

    assign ip_inc     = ip + ADDR_W'(1);
    assign oInstrAddr = ip;
    assign oLcdValid  = (state == ST_LCD_WAIT);
    assign oHalted    = (state == ST_HALT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_FETCH;
            ip        <= '0;
            oRegWrite <= 1'b0;
        end else begin
            state     <= state_nxt;
            ip        <= ip_nxt;
            oRegWrite <= regwrite_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ip_nxt       = ip;
        regwrite_nxt = 1'b0;
`ifdef MINI_SEQ_CALL_STACK_EN
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        fault_set    = 1'b0;
`endif
        case (state)
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                ip_nxt    = ip_inc;
                case (iOpcode)
                    OP_ALU: regwrite_nxt = 1'b1;
                    OP_BRC: if (iCond) ip_nxt = iTarget;
                    OP_JMP: ip_nxt = iTarget;
                    OP_LCD: begin
                        state_nxt = ST_LCD_WAIT;
                        ip_nxt    = ip;
                    end
                    OP_HALT: begin
                        state_nxt = ST_HALT;
                        ip_nxt    = ip;
                    end
`ifdef MINI_SEQ_CALL_STACK_EN
                    OP_CALL: begin
                        if (stk_full) begin
                            fault_set = 1'b1;
                            state_nxt = ST_HALT;
                            ip_nxt    = ip;
                        end else begin
                            stk_push = 1'b1;
                            ip_nxt   = iTarget;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            fault_set = 1'b1;
                            state_nxt = ST_HALT;
                            ip_nxt    = ip;
                        end else begin
                            stk_pop = 1'b1;
                            ip_nxt  = stk_data;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            ST_LCD_WAIT: begin
                if (iLcdReady) begin
                    state_nxt = ST_FETCH;
                    ip_nxt    = ip_inc;
                end
            end
            ST_HALT: ;
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed bench: instruction-level model builds a per-cycle expected trace, one process compares it.
module tb_mini_alu_sequencer;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXC  = 64;
    localparam int ROMN  = 1 << AW;
`ifdef MINI_SEQ_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] oInstrAddr;
    logic [3:0]    iOpcode = '0;
    logic [AW-1:0] iTarget = '0;
    logic          iCond = 1'b0;
    logic          oRegWrite, oLcdValid, oHalted, oFault;
    logic          iLcdReady = 1'b0;

    mini_alu_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .oInstrAddr (oInstrAddr),
        .iOpcode    (iOpcode),
        .iTarget    (iTarget),
        .iCond      (iCond),
        .oRegWrite  (oRegWrite),
        .oLcdValid  (oLcdValid),
        .iLcdReady  (iLcdReady),
        .oHalted    (oHalted),
        .oFault     (oFault)
    );

    always #5 Clock = ~Clock;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] rom_op  [ROMN];
    int         rom_tgt [ROMN];
    logic       rdy     [MAXC];
    logic       cond;
    int         e_addr  [MAXC];
    logic       e_rw [MAXC], e_lv [MAXC], e_h [MAXC], e_f [MAXC];
    int         cyc = 0;
    logic       cmp_en = 1'b0;
    string      tname = "";

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (cmp_en) begin
            check($sformatf("%s addr c%0d", tname, cyc), int'(oInstrAddr), e_addr[cyc]);
            check($sformatf("%s regwrite c%0d", tname, cyc), int'(oRegWrite), int'(e_rw[cyc]));
            check($sformatf("%s lcdvalid c%0d", tname, cyc), int'(oLcdValid), int'(e_lv[cyc]));
            check($sformatf("%s halted c%0d", tname, cyc), int'(oHalted), int'(e_h[cyc]));
            check($sformatf("%s fault c%0d", tname, cyc), int'(oFault), int'(e_f[cyc]));
        end
    end

    // Instruction-level interpreter; cycle 0 is the first cycle after reset release.
    int   m_t, m_n, m_ip;
    logic m_rw, m_h, m_f;

    task automatic emit(input logic lv);
        if (m_t < m_n) begin
            e_addr[m_t] = m_ip;
            e_rw[m_t]   = m_rw;
            e_lv[m_t]   = lv;
            e_h[m_t]    = m_h;
            e_f[m_t]    = m_f;
        end
        m_rw = 1'b0;
        m_t++;
    endtask

    task automatic build_model(input int n);
        int   stk[$];
        int   op, tgt;
        logic done;
        m_n = n; m_t = 0; m_ip = 0; m_rw = 1'b0; m_h = 1'b0; m_f = 1'b0;
        while (m_t < n) begin
            if (m_h) begin
                emit(1'b0);
            end else begin
                emit(1'b0);
                op  = int'(rom_op[m_ip]);
                tgt = rom_tgt[m_ip];
                emit(1'b0);
                case (op)
                    1: begin m_rw = 1'b1; m_ip = (m_ip + 1) % ROMN; end
                    2: m_ip = cond ? tgt : (m_ip + 1) % ROMN;
                    3: m_ip = tgt;
                    4: begin
                        done = 1'b0;
                        while (!done && m_t < n) begin
                            done = rdy[m_t];
                            emit(1'b1);
                        end
                        if (done) m_ip = (m_ip + 1) % ROMN;
                    end
                    5: begin
                        if (!STK) m_ip = (m_ip + 1) % ROMN;
                        else if (stk.size() == DEPTH) begin m_f = 1'b1; m_h = 1'b1; end
                        else begin stk.push_back((m_ip + 1) % ROMN); m_ip = tgt; end
                    end
                    6: begin
                        if (!STK) m_ip = (m_ip + 1) % ROMN;
                        else if (stk.size() == 0) begin m_f = 1'b1; m_h = 1'b1; end
                        else m_ip = stk.pop_back();
                    end
                    7: m_h = 1'b1;
                    default: m_ip = (m_ip + 1) % ROMN;
                endcase
            end
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < ROMN; i++) begin rom_op[i] = 4'd0; rom_tgt[i] = 0; end
        for (int i = 0; i < MAXC; i++) rdy[i] = 1'b0;
        cond = 1'b0;
    endtask

    // ROM is modelled with one cycle of read latency from the address seen last cycle.
    task automatic run(input string name, input int n);
        int prev_addr;
        tname = name;
        Reset = 1'b1; iLcdReady = 1'b0;
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b0;
        prev_addr = 0;
        for (int t = 0; t < n; t++) begin
            cyc       = t;
            iCond     = cond;
            iLcdReady = rdy[t];
            iOpcode   = rom_op[prev_addr];
            iTarget   = AW'(rom_tgt[prev_addr]);
            cmp_en    = 1'b1;
            @(negedge Clock);
            prev_addr = int'(oInstrAddr);
            @(posedge Clock); #1;
        end
        cmp_en = 1'b0;
    endtask

    initial begin
        clear_prog();
        rom_op[0] = 4'd1; rom_op[1] = 4'd1; rom_op[2] = 4'd7;
        build_model(12);
        check("pin alu rw c2", int'(e_rw[2]), 1);
        check("pin alu rw c3", int'(e_rw[3]), 0);
        check("pin alu rw c4", int'(e_rw[4]), 1);
        check("pin alu halted c5", int'(e_h[5]), 0);
        check("pin alu halted c6", int'(e_h[6]), 1);
        check("pin alu addr c11", e_addr[11], 2);
        run("alu_halt", 12);

        clear_prog();
        rom_op[0] = 4'd2; rom_tgt[0] = 9; rom_op[9] = 4'd7; rom_op[1] = 4'd7; cond = 1'b1;
        build_model(6);
        check("pin brc taken addr c2", e_addr[2], 9);
        run("brc_taken", 6);
        cond = 1'b0;
        build_model(6);
        check("pin brc not taken addr c2", e_addr[2], 1);
        run("brc_not_taken", 6);

        clear_prog();
        rom_op[0] = 4'd4; rom_op[1] = 4'd7;
        rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[7] = 1'b1; rdy[8] = 1'b1;
        build_model(12);
        check("pin lcd valid c1", int'(e_lv[1]), 0);
        check("pin lcd valid c2", int'(e_lv[2]), 1);
        check("pin lcd valid c7", int'(e_lv[7]), 1);
        check("pin lcd valid c8", int'(e_lv[8]), 0);
        check("pin lcd addr c8", e_addr[8], 1);
        run("lcd", 12);

        clear_prog();
        rom_op[0] = 4'd4;
        build_model(5);
        run("lcd_stall", 5);
        Reset = 1'b1; iLcdReady = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0; iLcdReady = 1'b0;
        @(negedge Clock);
        check("reset in lcd_wait lcdvalid", int'(oLcdValid), 0);
        check("reset in lcd_wait addr", int'(oInstrAddr), 0);
        check("reset in lcd_wait regwrite", int'(oRegWrite), 0);
        check("reset in lcd_wait halted", int'(oHalted), 0);

        clear_prog();
        rom_op[0] = 4'd3; rom_tgt[0] = 15; rom_op[15] = 4'd0; rom_op[1] = 4'd7;
        build_model(8);
        check("pin wrap addr c2", e_addr[2], 15);
        check("pin wrap addr c4", e_addr[4], 0);
        run("jmp_wrap", 8);

        clear_prog();
        rom_op[0] = 4'd0; rom_op[1] = 4'd12; rom_op[2] = 4'd3; rom_tgt[2] = 5;
        rom_op[5] = 4'd1; rom_op[6] = 4'd15; rom_op[7] = 4'd7;
        build_model(16);
        check("pin mix addr c6", e_addr[6], 5);
        check("pin mix rw c8", int'(e_rw[8]), 1);
        run("mix", 16);

`ifdef MINI_SEQ_CALL_STACK_EN
        clear_prog();
        for (int k = 0; k < 5; k++) begin rom_op[k] = 4'd5; rom_tgt[k] = k + 1; end
        build_model(14);
        check("pin overflow fault c9", int'(e_f[9]), 0);
        check("pin overflow fault c10", int'(e_f[10]), 1);
        check("pin overflow halted c10", int'(e_h[10]), 1);
        check("pin overflow addr c13", e_addr[13], 4);
        run("call_overflow", 14);

        clear_prog();
        rom_op[0] = 4'd6;
        build_model(5);
        check("pin ret empty fault c2", int'(e_f[2]), 1);
        run("ret_empty", 5);

        clear_prog();
        rom_op[0] = 4'd5; rom_tgt[0] = 5; rom_op[5] = 4'd1; rom_op[6] = 4'd6; rom_op[1] = 4'd7;
        build_model(10);
        check("pin call_ret addr c2", e_addr[2], 5);
        check("pin call_ret addr c6", e_addr[6], 1);
        run("call_ret", 10);
`else
        clear_prog();
        rom_op[0] = 4'd5; rom_tgt[0] = 7; rom_op[1] = 4'd6; rom_op[2] = 4'd7;
        build_model(8);
        check("pin call nop addr c2", e_addr[2], 1);
        check("pin ret nop addr c4", e_addr[4], 2);
        check("pin call nop fault c3", int'(e_f[3]), 0);
        run("call_ret_nop", 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
